// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one decimal digit per clock, LSB digit first.
// Result, carry and operand-error flag are registered and held until the next accepted start.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry;
    logic [IW-1:0] idx;

    logic [3:0]    a_d;
    logic [3:0]    b_d;
    logic [4:0]    t;
    logic [3:0]    digit;
    logic          carry_nxt;
    logic          bad_in;

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        a_d       = a_q[4*int'(idx) +: 4];
        b_d       = b_q[4*int'(idx) +: 4];
        t         = 5'(a_d) + 5'(b_d) + 5'(carry);
        digit     = t[3:0];
        carry_nxt = 1'b0;
        if (t > 5'd9) begin
            // 4-bit wrap of the +6 correction is the mod-16 the decimal adjust needs.
            digit     = t[3:0] + 4'd6;
            carry_nxt = 1'b1;
        end
    end

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= bad_in;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[4*int'(idx) +: 4] <= digit;
                    carry <= carry_nxt;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        cout  <= carry_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: stimulus pushes expected results, a negedge monitor
// pops and compares on every done pulse and tracks busy against the expected busy window.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   busy_from = 1;
    int   busy_to   = 0;
    bit   mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal integer arithmetic for valid operands, per-digit adjust rule otherwise.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        int   dx;
        int   dy;
        int   xd;
        int   yd;
        int   t;
        int   total;
        int   pw;
        int   carry;
        bit   bad;
        e.sum = '0;
        e.cout = 1'b0;
        e.done_cyc = 0;
        dx = 0;
        dy = 0;
        pw = 1;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            xd = int'(x[4*i +: 4]);
            yd = int'(y[4*i +: 4]);
            if (xd > 9 || yd > 9) bad = 1'b1;
            dx = dx * 10 + xd;
            dy = dy * 10 + yd;
            pw = pw * 10;
        end
        e.err = bad;
        if (!bad) begin
            total  = dx + dy + int'(c);
            e.cout = (total >= pw);
            total  = total % pw;
            for (int i = 0; i < DIGITS; i++) begin
                e.sum[4*i +: 4] = 4'(total % 10);
                total = total / 10;
            end
        end else begin
            carry = int'(c);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + carry;
                if (t > 9) begin
                    e.sum[4*i +: 4] = 4'((t + 6) % 16);
                    carry = 1;
                end else begin
                    e.sum[4*i +: 4] = 4'(t);
                    carry = 0;
                end
            end
            e.cout = (carry != 0);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        int           pos;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) begin
            pos = int'($urandom_range(0, DIGITS - 1));
            v[4*pos +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start=1 across one edge; the DUT is known idle by bench timing.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output exp_t e);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        tick();
        e          = model(x, y, c);
        e.done_cyc = cyc + DIGITS;
        sb.push_back(e);
        busy_from  = cyc;
        busy_to    = cyc + DIGITS;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        issue(x, y, c, e);
        start = 1'b0;
        repeat (DIGITS + 1) tick();
        check("sum_hold_idle", sum, e.sum);
        check("cout_hold_idle", cout, e.cout);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, (cyc >= busy_from && cyc <= busy_to));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("sum", sum, mon_e.sum);
                    check("cout", cout, mon_e.cout);
                    check("err", err, mon_e.err);
                end
            end else begin
                check("done_low", done, 1'b0);
                if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_done: got no done expected done at cycle %0d", sb[0].done_cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t         e;
        logic [W-1:0] x2;
        logic [W-1:0] y2;
        logic         c2;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) tick();
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // Directed vectors, including carry ripple through all digits and an invalid digit.
        run_op(16'h0099, 16'h0001, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1);
        run_op(16'h1234, 16'h5678, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1);
        run_op(16'h00A0, 16'h0000, 1'b0);
        check("err_hold_idle", err, 1'b1);
        run_op(16'h0012, 16'h0034, 1'b0);
        check("err_cleared", err, 1'b0);

        // start pulsed during ADD with new operands must be dropped.
        issue(16'h4321, 16'h1111, 1'b0, e);
        a     = 16'h9999;
        b     = 16'h8888;
        cin   = 1'b1;
        tick();
        start = 1'b0;
        repeat (DIGITS) tick();
        check("ignored_start_sum", sum, e.sum);

        // Reset on the third ADD cycle aborts with no done pulse.
        issue(16'h5A55, 16'h1111, 1'b0, e);
        start = 1'b0;
        repeat (2) tick();
        rst     = 1'b1;
        busy_to = cyc;
        sb.delete();
        tick();
        rst = 1'b0;
        check("abort_sum", sum, '0);
        check("abort_cout", cout, 1'b0);
        check("abort_err", err, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        run_op(16'h0505, 16'h0505, 1'b1);

        // start held high across two operations: second accepted DIGITS+2 edges after the first.
        x2 = rand_bcd();
        y2 = rand_bcd();
        c2 = 1'($urandom_range(0, 1));
        issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), e);
        a   = x2;
        b   = y2;
        cin = c2;
        repeat (DIGITS + 1) tick();
        issue(x2, y2, c2, e);
        start = 1'b0;
        repeat (DIGITS + 1) tick();

        for (int n = 0; n < 24; n++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
